peripheral_arbiter_wb: RTL and testbench
========================================

PERIPHERAL_ARBITER_WB -- requirements
Module: peripheral_arbiter_wb

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 2 (range 2..8): number of requesting Wishbone masters.
REQ-002 SHALL have parameter AW, default 32: address width.
REQ-003 SHALL have parameter DW, default 32: data width.
REQ-004 SHALL have parameter TIMEOUT, default 255: cycles without slave ack/err/rty before abort.
REQ-005 SHALL have port wb_clk_i, input, 1: single clock, all logic on rising edge.
REQ-006 SHALL have port wb_rst_i, input, 1: reset, asynchronous assert, active-low.
REQ-007 SHALL have port m_adr_i, input, NUM_MASTERS*AW: packed master addresses, master k at slice k.
REQ-008 SHALL have ports m_dat_i (NUM_MASTERS*DW), m_sel_i (NUM_MASTERS*4), m_cti_i (NUM_MASTERS*3), m_bte_i (NUM_MASTERS*2), inputs: packed master qualifiers.
REQ-009 SHALL have ports m_we_i, m_cyc_i, m_stb_i, inputs, NUM_MASTERS each: per-master strobes.
REQ-010 SHALL have port m_dat_o, output, DW: slave read data broadcast to all masters.
REQ-011 SHALL have ports m_ack_o, m_err_o, m_rty_o, outputs, NUM_MASTERS each: per-master responses.
REQ-012 SHALL have ports s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o, s_cti_o, s_bte_o, outputs: single slave port, widths AW/DW/4/1/1/1/3/2.
REQ-013 SHALL have ports s_dat_i (DW), s_ack_i, s_err_i, s_rty_i, inputs: slave responses.
REQ-014 SHALL have port grant_o, output, NUM_MASTERS: one-hot current owner, all-zero when idle.

Function
REQ-015 SHALL implement FSM states IDLE, OWNED, ABORT.
REQ-016 IDLE: when any m_cyc_i high, SHALL register grant to the first requester at or after (last_owner+1) modulo NUM_MASTERS, go OWNED next cycle; one-cycle arbitration latency.
REQ-017 IDLE: s_cyc_o, s_stb_o, all m_ack_o/m_err_o/m_rty_o SHALL be 0.
REQ-018 OWNED: slave outputs SHALL combinationally mirror owner's inputs; owner's ack/err/rty SHALL mirror s_ack_i/s_err_i/s_rty_i; non-owners' responses 0.
REQ-019 OWNED SHALL persist while owner m_cyc_i high, across bursts (cti 001/010) and multiple stb phases; no preemption.
REQ-020 Owner m_cyc_i low SHALL return to IDLE next cycle, last_owner updated, grant_o cleared.
REQ-021 Watchdog counter SHALL clear on entering OWNED and on each s_ack_i/s_err_i/s_rty_i, increment while s_stb_o high without response; reaching TIMEOUT SHALL enter ABORT.
REQ-022 ABORT: s_cyc_o/s_stb_o SHALL be 0, owner m_err_o SHALL be 1 for exactly one cycle, then hold until owner drops m_cyc_i, then IDLE.
REQ-023 Simultaneous requests SHALL resolve strictly round-robin; a master re-requesting right after release SHALL lose to any other pending requester.
REQ-024 Counter width SHALL be $clog2(TIMEOUT+1); TIMEOUT=0 SHALL disable watchdog.

Reset
REQ-025 Reset asserted SHALL force IDLE, grant_o=0, last_owner=NUM_MASTERS-1 (master 0 wins first), counter=0, all s_* and m_ack/err/rty outputs 0.
REQ-026 Reset mid-OWNED SHALL drop s_cyc_o immediately (asynchronously); no response delivered to the aborted master.

Structure
REQ-027 Shared package peripheral_arbiter_wb_pkg SHALL hold state enum and CTI/BTE constants (CTI_CLASSIC=000, CTI_INCR=010, CTI_EOB=111).
REQ-028 Round-robin selection SHALL be a sub-module peripheral_arbiter_rr (req, last_owner -> one-hot next grant), purely combinational.

Verification
REQ-029 Single master 0 write adr 0x10 data 0xDEADBEEF -> grant_o=01 one cycle after cyc, memory read-back 0xDEADBEEF.
REQ-030 Masters 0 and 1 request same cycle after reset -> master 0 served first, master 1 granted the cycle after master 0 drops cyc.
REQ-031 Master 1 INCR burst of 4 while master 0 requests -> four acks to master 1, no response to master 0 until burst EOB and cyc release.
REQ-032 Slave never acks, TIMEOUT=8 -> m_err_o of owner high one cycle at 8th stalled cycle, s_cyc_o low, state IDLE after owner drops cyc.
REQ-033 wb_rst_i low during OWNED -> s_cyc_o and grant_o 0 in same cycle, master 0 wins first grant after release.

Source files
------------

// File: rtl/peripheral_arbiter_wb_pkg.sv
//------------------------------------------------------------------------------
// Module   : peripheral_arbiter_wb_pkg
// Brief    : Shared types and Wishbone cycle-type constants for the arbiter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package peripheral_arbiter_wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWNED = 2'd1,
        ST_ABORT = 2'd2
    } arb_state_e;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_CONST   = 3'b001;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    // Up to eight masters, so a fixed 8-bit one-hot covers every configuration.
    function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
        logic [2:0] w_idx;
        w_idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) begin
                w_idx = 3'(i);
            end
        end
        return w_idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/peripheral_arbiter_rr.sv
//------------------------------------------------------------------------------
// Module   : peripheral_arbiter_rr
// Brief    : Combinational round-robin picker: first requester after last owner.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module peripheral_arbiter_rr #(
    parameter int NUM_MASTERS = 2,
    parameter int IDX_W       = 1
) (
    input  logic [NUM_MASTERS-1:0] i_req,
    input  logic [IDX_W-1:0]       i_last_owner,
    output logic [NUM_MASTERS-1:0] o_grant
);

    logic [IDX_W-1:0] w_idx;

    // Scan starts one past the last owner so it is checked last.
    always_comb begin
        o_grant = '0;
        w_idx   = '0;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            w_idx = IDX_W'((int'(i_last_owner) + i) % NUM_MASTERS);
            if (i_req[w_idx] && (o_grant == '0)) begin
                o_grant[w_idx] = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/peripheral_arbiter_wb.sv
//------------------------------------------------------------------------------
// Module   : peripheral_arbiter_wb
// Brief    : N-master to 1-slave Wishbone arbiter, round-robin, with watchdog.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module peripheral_arbiter_wb
    import peripheral_arbiter_wb_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int TIMEOUT     = 255
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    input  logic [NUM_MASTERS*AW-1:0] m_adr_i,
    input  logic [NUM_MASTERS*DW-1:0] m_dat_i,
    input  logic [NUM_MASTERS*4-1:0]  m_sel_i,
    input  logic [NUM_MASTERS*3-1:0]  m_cti_i,
    input  logic [NUM_MASTERS*2-1:0]  m_bte_i,
    input  logic [NUM_MASTERS-1:0]    m_we_i,
    input  logic [NUM_MASTERS-1:0]    m_cyc_i,
    input  logic [NUM_MASTERS-1:0]    m_stb_i,
    output logic [DW-1:0]             m_dat_o,
    output logic [NUM_MASTERS-1:0]    m_ack_o,
    output logic [NUM_MASTERS-1:0]    m_err_o,
    output logic [NUM_MASTERS-1:0]    m_rty_o,
    output logic [AW-1:0]             s_adr_o,
    output logic [DW-1:0]             s_dat_o,
    output logic [3:0]                s_sel_o,
    output logic                      s_we_o,
    output logic                      s_cyc_o,
    output logic                      s_stb_o,
    output logic [2:0]                s_cti_o,
    output logic [1:0]                s_bte_o,
    input  logic [DW-1:0]             s_dat_i,
    input  logic                      s_ack_i,
    input  logic                      s_err_i,
    input  logic                      s_rty_i,
    output logic [NUM_MASTERS-1:0]    grant_o
);

    localparam int c_IDX_W  = $clog2(NUM_MASTERS);
    localparam int c_WDOG_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [c_WDOG_W-1:0] c_WDOG_LAST = c_WDOG_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    arb_state_e               r_state, w_state_nxt;
    logic [c_IDX_W-1:0]       r_owner, w_owner_nxt;
    logic [c_IDX_W-1:0]       r_last_owner, w_last_owner_nxt;
    logic [NUM_MASTERS-1:0]   r_grant, w_grant_nxt;
    logic [c_WDOG_W-1:0]      r_wdog, w_wdog_nxt;
    logic                     r_err_pend, w_err_pend_nxt;
    logic [NUM_MASTERS-1:0]   w_rr_grant;

    peripheral_arbiter_rr #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_W       (c_IDX_W)
    ) u_rr (
        .i_req        (m_cyc_i),
        .i_last_owner (r_last_owner),
        .o_grant      (w_rr_grant)
    );

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            r_state      <= ST_IDLE;
            r_owner      <= '0;
            r_last_owner <= c_IDX_W'(NUM_MASTERS - 1);
            r_grant      <= '0;
            r_wdog       <= '0;
            r_err_pend   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_owner      <= w_owner_nxt;
            r_last_owner <= w_last_owner_nxt;
            r_grant      <= w_grant_nxt;
            r_wdog       <= w_wdog_nxt;
            r_err_pend   <= w_err_pend_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_owner_nxt      = r_owner;
        w_last_owner_nxt = r_last_owner;
        w_grant_nxt      = r_grant;
        w_wdog_nxt       = r_wdog;
        w_err_pend_nxt   = 1'b0;

        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_we_o  = 1'b0;
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_cti_o = '0;
        s_bte_o = '0;
        m_ack_o = '0;
        m_err_o = '0;
        m_rty_o = '0;

        case (r_state)
            ST_IDLE: begin
                if (|m_cyc_i) begin
                    w_state_nxt = ST_OWNED;
                    w_grant_nxt = w_rr_grant;
                    w_owner_nxt = c_IDX_W'(onehot_to_idx(8'(w_rr_grant)));
                    w_wdog_nxt  = '0;
                end
            end

            ST_OWNED: begin
                s_adr_o = m_adr_i[int'(r_owner)*AW +: AW];
                s_dat_o = m_dat_i[int'(r_owner)*DW +: DW];
                s_sel_o = m_sel_i[int'(r_owner)*4 +: 4];
                s_cti_o = m_cti_i[int'(r_owner)*3 +: 3];
                s_bte_o = m_bte_i[int'(r_owner)*2 +: 2];
                s_we_o  = m_we_i[r_owner];
                s_cyc_o = m_cyc_i[r_owner];
                s_stb_o = m_stb_i[r_owner];
                m_ack_o[r_owner] = s_ack_i;
                m_err_o[r_owner] = s_err_i;
                m_rty_o[r_owner] = s_rty_i;

                if (!m_cyc_i[r_owner]) begin
                    w_state_nxt      = ST_IDLE;
                    w_grant_nxt      = '0;
                    w_last_owner_nxt = r_owner;
                    w_wdog_nxt       = '0;
                end else if (s_ack_i || s_err_i || s_rty_i) begin
                    w_wdog_nxt = '0;
                end else if (m_stb_i[r_owner]) begin
                    w_wdog_nxt = r_wdog + 1'b1;
                    // Abort once the count reaches TIMEOUT stalled cycles.
                    if ((TIMEOUT != 0) && (r_wdog == c_WDOG_LAST)) begin
                        w_state_nxt    = ST_ABORT;
                        w_err_pend_nxt = 1'b1;
                    end
                end
            end

            ST_ABORT: begin
                m_err_o[r_owner] = r_err_pend;
                if (!m_cyc_i[r_owner]) begin
                    w_state_nxt      = ST_IDLE;
                    w_grant_nxt      = '0;
                    w_last_owner_nxt = r_owner;
                    w_wdog_nxt       = '0;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    assign m_dat_o = s_dat_i;
    assign grant_o = r_grant;

endmodule

`default_nettype wire

// File: tb/tb_peripheral_arbiter_wb.sv
//------------------------------------------------------------------------------
// Module   : tb_peripheral_arbiter_wb
// Brief    : Vector-table and directed-sequence bench for the Wishbone arbiter.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_peripheral_arbiter_wb;
    import peripheral_arbiter_wb_pkg::*;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N*AW-1:0] m_adr;
    logic [N*DW-1:0] m_dat;
    logic [N*4-1:0]  m_sel;
    logic [N*3-1:0]  m_cti;
    logic [N*2-1:0]  m_bte;
    logic [N-1:0]    m_we, m_cyc, m_stb;
    logic [DW-1:0]   m_dat_o;
    logic [N-1:0]    m_ack_o, m_err_o, m_rty_o;
    logic [AW-1:0]   s_adr_o;
    logic [DW-1:0]   s_dat_o;
    logic [3:0]      s_sel_o;
    logic            s_we_o, s_cyc_o, s_stb_o;
    logic [2:0]      s_cti_o;
    logic [1:0]      s_bte_o;
    logic [DW-1:0]   s_dat_i;
    logic            s_ack_i, s_err_i, s_rty_i;
    logic [N-1:0]    grant_o;

    logic [1:0]      resp_mode;
    logic [31:0]     mem [0:15];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    peripheral_arbiter_wb #(
        .NUM_MASTERS (N),
        .AW          (AW),
        .DW          (DW),
        .TIMEOUT     (TO)
    ) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst_n),
        .m_adr_i  (m_adr),
        .m_dat_i  (m_dat),
        .m_sel_i  (m_sel),
        .m_cti_i  (m_cti),
        .m_bte_i  (m_bte),
        .m_we_i   (m_we),
        .m_cyc_i  (m_cyc),
        .m_stb_i  (m_stb),
        .m_dat_o  (m_dat_o),
        .m_ack_o  (m_ack_o),
        .m_err_o  (m_err_o),
        .m_rty_o  (m_rty_o),
        .s_adr_o  (s_adr_o),
        .s_dat_o  (s_dat_o),
        .s_sel_o  (s_sel_o),
        .s_we_o   (s_we_o),
        .s_cyc_o  (s_cyc_o),
        .s_stb_o  (s_stb_o),
        .s_cti_o  (s_cti_o),
        .s_bte_o  (s_bte_o),
        .s_dat_i  (s_dat_i),
        .s_ack_i  (s_ack_i),
        .s_err_i  (s_err_i),
        .s_rty_i  (s_rty_i),
        .grant_o  (grant_o)
    );

    // Zero-wait memory slave; resp_mode picks ack (1), err (2), rty (3) or stall (0).
    assign s_ack_i = s_cyc_o & s_stb_o & (resp_mode == 2'd1);
    assign s_err_i = s_cyc_o & s_stb_o & (resp_mode == 2'd2);
    assign s_rty_i = s_cyc_o & s_stb_o & (resp_mode == 2'd3);
    assign s_dat_i = mem[s_adr_o[5:2]];

    always @(posedge clk) begin
        if (s_cyc_o && s_stb_o && s_we_o && s_ack_i) begin
            mem[s_adr_o[5:2]] <= s_dat_o;
        end
    end

    typedef struct {
        logic        rst_n;
        logic [1:0]  cyc;
        logic [1:0]  stb;
        logic [1:0]  resp;
        logic [1:0]  exp_grant;
        logic        exp_scyc;
        logic [1:0]  exp_ack;
        logic [1:0]  exp_err;
        logic [1:0]  exp_rty;
        logic [31:0] exp_adr;
    } vec_t;

    vec_t vecs [23];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic set_m(input int k, input logic cyc, input logic stb, input logic we,
                         input logic [31:0] adr, input logic [31:0] dat, input logic [2:0] cti);
        m_cyc[k]           = cyc;
        m_stb[k]           = stb;
        m_we[k]            = we;
        m_adr[k*AW +: AW]  = adr;
        m_dat[k*DW +: DW]  = dat;
        m_cti[k*3 +: 3]    = cti;
    endtask

    initial begin
        //          rst   cyc    stb    resp  grant  scyc  ack    err    rty    adr
        vecs[0]  = '{1'b0, 2'b00, 2'b00, 2'd1, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 32'h00};
        vecs[1]  = '{1'b1, 2'b11, 2'b11, 2'd1, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 32'h00};
        vecs[2]  = '{1'b1, 2'b11, 2'b11, 2'd1, 2'b01, 1'b1, 2'b01, 2'b00, 2'b00, 32'h10};
        vecs[3]  = '{1'b1, 2'b10, 2'b10, 2'd1, 2'b01, 1'b0, 2'b00, 2'b00, 2'b00, 32'h10};
        vecs[4]  = '{1'b1, 2'b10, 2'b10, 2'd1, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 32'h00};
        vecs[5]  = '{1'b1, 2'b10, 2'b10, 2'd1, 2'b10, 1'b1, 2'b10, 2'b00, 2'b00, 32'h20};
        vecs[6]  = '{1'b1, 2'b11, 2'b11, 2'd1, 2'b10, 1'b1, 2'b10, 2'b00, 2'b00, 32'h20};
        vecs[7]  = '{1'b1, 2'b01, 2'b01, 2'd1, 2'b10, 1'b0, 2'b00, 2'b00, 2'b00, 32'h20};
        vecs[8]  = '{1'b1, 2'b01, 2'b01, 2'd1, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 32'h00};
        vecs[9]  = '{1'b1, 2'b01, 2'b01, 2'd1, 2'b01, 1'b1, 2'b01, 2'b00, 2'b00, 32'h10};
        vecs[10] = '{1'b1, 2'b11, 2'b11, 2'd1, 2'b01, 1'b1, 2'b01, 2'b00, 2'b00, 32'h10};
        vecs[11] = '{1'b1, 2'b10, 2'b10, 2'd1, 2'b01, 1'b0, 2'b00, 2'b00, 2'b00, 32'h10};
        vecs[12] = '{1'b1, 2'b11, 2'b11, 2'd1, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 32'h00};
        vecs[13] = '{1'b1, 2'b11, 2'b11, 2'd1, 2'b10, 1'b1, 2'b10, 2'b00, 2'b00, 32'h20};
        vecs[14] = '{1'b1, 2'b00, 2'b00, 2'd1, 2'b10, 1'b0, 2'b00, 2'b00, 2'b00, 32'h20};
        vecs[15] = '{1'b1, 2'b00, 2'b00, 2'd1, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 32'h00};
        vecs[16] = '{1'b1, 2'b01, 2'b01, 2'd0, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 32'h00};
        vecs[17] = '{1'b1, 2'b01, 2'b01, 2'd0, 2'b01, 1'b1, 2'b00, 2'b00, 2'b00, 32'h10};
        vecs[18] = '{1'b1, 2'b01, 2'b01, 2'd2, 2'b01, 1'b1, 2'b00, 2'b01, 2'b00, 32'h10};
        vecs[19] = '{1'b1, 2'b01, 2'b01, 2'd3, 2'b01, 1'b1, 2'b00, 2'b00, 2'b01, 32'h10};
        vecs[20] = '{1'b1, 2'b01, 2'b01, 2'd1, 2'b01, 1'b1, 2'b01, 2'b00, 2'b00, 32'h10};
        vecs[21] = '{1'b1, 2'b00, 2'b00, 2'd1, 2'b01, 1'b0, 2'b00, 2'b00, 2'b00, 32'h10};
        vecs[22] = '{1'b1, 2'b00, 2'b00, 2'd1, 2'b00, 1'b0, 2'b00, 2'b00, 2'b00, 32'h00};

        rst_n     = 1'b0;
        resp_mode = 2'd1;
        m_cyc     = '0;
        m_stb     = '0;
        m_we      = '0;
        m_sel     = '1;
        m_bte     = '0;
        m_cti     = '0;
        m_dat     = '0;
        m_adr     = {32'h20, 32'h10};
        repeat (2) @(posedge clk);

        // Cycle-by-cycle table: inputs applied after an edge, outputs checked mid-cycle.
        for (int i = 0; i < 23; i++) begin
            tick();
            rst_n     = vecs[i].rst_n;
            m_cyc     = vecs[i].cyc;
            m_stb     = vecs[i].stb;
            resp_mode = vecs[i].resp;
            mid();
            check($sformatf("v%0d grant", i), 32'(grant_o), 32'(vecs[i].exp_grant));
            check($sformatf("v%0d s_cyc", i), 32'(s_cyc_o), 32'(vecs[i].exp_scyc));
            check($sformatf("v%0d ack", i),   32'(m_ack_o), 32'(vecs[i].exp_ack));
            check($sformatf("v%0d err", i),   32'(m_err_o), 32'(vecs[i].exp_err));
            check($sformatf("v%0d rty", i),   32'(m_rty_o), 32'(vecs[i].exp_rty));
            check($sformatf("v%0d s_adr", i), s_adr_o,      vecs[i].exp_adr);
        end

        // Single write then read-back by master 0.
        tick();
        resp_mode = 2'd1;
        set_m(0, 1'b1, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, CTI_CLASSIC);
        mid();
        check("wr arb latency", 32'(grant_o), 32'h0);
        tick();
        mid();
        check("wr grant", 32'(grant_o), 32'h1);
        check("wr ack", 32'(m_ack_o), 32'h1);
        check("wr s_dat", s_dat_o, 32'hDEADBEEF);
        check("wr s_we", 32'(s_we_o), 32'h1);
        tick();
        set_m(0, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0, CTI_CLASSIC);
        tick();
        set_m(0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0, CTI_CLASSIC);
        tick();
        mid();
        check("rd ack", 32'(m_ack_o), 32'h1);
        check("rd data", m_dat_o, 32'hDEADBEEF);
        tick();
        set_m(0, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0, CTI_CLASSIC);
        tick();

        // Master 1 incrementing burst while master 0 waits.
        tick();
        set_m(0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0, CTI_CLASSIC);
        set_m(1, 1'b1, 1'b1, 1'b1, 32'h20, 32'hA0, CTI_INCR);
        mid();
        check("burst arb", 32'(grant_o), 32'h0);
        for (int b = 0; b < 4; b++) begin
            tick();
            set_m(1, 1'b1, 1'b1, 1'b1, 32'h20 + 32'(4 * b), 32'hA0 + 32'(b),
                  (b == 3) ? CTI_EOB : CTI_INCR);
            mid();
            check($sformatf("burst b%0d grant", b), 32'(grant_o), 32'h2);
            check($sformatf("burst b%0d ack", b), 32'(m_ack_o), 32'h2);
            check($sformatf("burst b%0d cti", b), 32'(s_cti_o), (b == 3) ? 32'h7 : 32'h2);
        end
        tick();
        set_m(1, 1'b0, 1'b0, 1'b0, 32'h20, 32'h0, CTI_CLASSIC);
        mid();
        check("burst release ack", 32'(m_ack_o), 32'h0);
        tick();
        mid();
        check("burst idle grant", 32'(grant_o), 32'h0);
        check("burst idle ack", 32'(m_ack_o), 32'h0);
        tick();
        mid();
        check("m0 after burst grant", 32'(grant_o), 32'h1);
        check("m0 after burst ack", 32'(m_ack_o), 32'h1);
        check("burst mem beat3", mem[11], 32'hA3);
        tick();
        set_m(0, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0, CTI_CLASSIC);
        tick();

        // Watchdog: slave never responds.
        tick();
        resp_mode = 2'd0;
        set_m(0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0, CTI_CLASSIC);
        mid();
        check("to arb", 32'(grant_o), 32'h0);
        for (int s = 1; s <= TO; s++) begin
            tick();
            mid();
            check($sformatf("to stall%0d err", s), 32'(m_err_o), 32'h0);
            check($sformatf("to stall%0d s_cyc", s), 32'(s_cyc_o), 32'h1);
        end
        tick();
        mid();
        check("to abort err", 32'(m_err_o), 32'h1);
        check("to abort s_cyc", 32'(s_cyc_o), 32'h0);
        check("to abort s_stb", 32'(s_stb_o), 32'h0);
        tick();
        mid();
        check("to err single", 32'(m_err_o), 32'h0);
        check("to hold s_cyc", 32'(s_cyc_o), 32'h0);
        tick();
        set_m(0, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0, CTI_CLASSIC);
        tick();
        mid();
        check("to idle grant", 32'(grant_o), 32'h0);

        // Asynchronous reset while master 0 owns the slave.
        tick();
        resp_mode = 2'd1;
        set_m(0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0, CTI_CLASSIC);
        tick();
        mid();
        check("pre-rst s_cyc", 32'(s_cyc_o), 32'h1);
        check("pre-rst grant", 32'(grant_o), 32'h1);
        #2;
        rst_n = 1'b0;
        set_m(1, 1'b1, 1'b1, 1'b0, 32'h20, 32'h0, CTI_CLASSIC);
        #1;
        check("rst s_cyc", 32'(s_cyc_o), 32'h0);
        check("rst grant", 32'(grant_o), 32'h0);
        check("rst ack", 32'(m_ack_o), 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        mid();
        check("post-rst idle", 32'(grant_o), 32'h0);
        tick();
        mid();
        check("post-rst first grant", 32'(grant_o), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
